// File: rtl/float_to_int_if.sv
// Handshake and data bundle between float_to_int and its requester.
// The requester drives start/floatIn; the converter answers with busy/done/OV/intOut.
interface float_to_int_if;
  logic        start;
  logic [31:0] floatIn;
  logic        busy;
  logic        done;
  logic        OV;
  logic [31:0] intOut;

  modport master (output start, floatIn, input busy, done, OV, intOut);
  modport slave  (input start, floatIn, output busy, done, OV, intOut);
endinterface

// File: rtl/float_to_int.sv
// Sequential IEEE-754 single-precision to signed 32-bit integer converter.
// The significand is aligned one bit per cycle; results saturate on Inf/NaN/overflow.
module float_to_int (
  input logic           clk,
  input logic           rst,
  float_to_int_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CLASSIFY, SHIFT, FINISH} stateT;

  stateT       state;
  stateT       nextState;

  logic        signReg;
  logic [7:0]  expReg;
  logic [22:0] mantReg;
  logic [31:0] shiftReg;
  logic [4:0]  count;
  logic        shiftLeft;
  logic        useSpecial;
  logic [31:0] specialVal;
  logic        specialOv;
  logic [31:0] intReg;
  logic        ovReg;
  logic        doneReg;

  logic        isSmall;
  logic        isHuge;
  logic        isAligned;

  assign isSmall   = (expReg < 8'd127);
  assign isHuge    = (expReg >= 8'd158);
  assign isAligned = (expReg == 8'd150);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Next-state logic: everything not needing alignment skips SHIFT
  always_comb begin
    nextState = state;
    case (state)
      IDLE:     if (bus.start) nextState = CLASSIFY;
      CLASSIFY: nextState = (isSmall || isHuge || isAligned) ? FINISH : SHIFT;
      SHIFT:    if (count == 5'd1) nextState = FINISH;
      FINISH:   nextState = IDLE;
      default:  nextState = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.busy   = (state != IDLE);
    bus.done   = doneReg;
    bus.OV     = ovReg;
    bus.intOut = intReg;
  end

  // Datapath: operand capture, classification, alignment and result registration
  always_ff @(posedge clk) begin
    if (rst) begin
      signReg    <= 1'b0;
      expReg     <= 8'd0;
      mantReg    <= 23'd0;
      shiftReg   <= 32'd0;
      count      <= 5'd0;
      shiftLeft  <= 1'b0;
      useSpecial <= 1'b0;
      specialVal <= 32'd0;
      specialOv  <= 1'b0;
      intReg     <= 32'd0;
      ovReg      <= 1'b0;
      doneReg    <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            signReg <= bus.floatIn[31];
            expReg  <= bus.floatIn[30:23];
            mantReg <= bus.floatIn[22:0];
          end
        end
        CLASSIFY: begin
          shiftReg   <= {8'b0, 1'b1, mantReg};
          useSpecial <= 1'b0;
          specialVal <= 32'd0;
          specialOv  <= 1'b0;
          count      <= 5'd0;
          shiftLeft  <= 1'b0;
          if (isSmall) begin
            useSpecial <= 1'b1;
          end else if (expReg == 8'd158 && signReg && mantReg == 23'd0) begin
            // -2^31 is the one value at this exponent that still fits
            useSpecial <= 1'b1;
            specialVal <= 32'h8000_0000;
          end else if (isHuge) begin
            useSpecial <= 1'b1;
            specialOv  <= 1'b1;
            specialVal <= signReg ? 32'h8000_0000 : 32'h7FFF_FFFF;
          end else if (expReg < 8'd150) begin
            count <= 5'(8'd150 - expReg);
          end else begin
            shiftLeft <= 1'b1;
            count     <= 5'(expReg - 8'd150);
          end
        end
        SHIFT: begin
          shiftReg <= shiftLeft ? (shiftReg << 1) : (shiftReg >> 1);
          count    <= count - 5'd1;
        end
        FINISH: begin
          if (useSpecial)   intReg <= specialVal;
          else if (signReg) intReg <= ~shiftReg + 32'd1;
          else              intReg <= shiftReg;
          ovReg   <= specialOv;
          doneReg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_float_to_int.sv
// Self-checking bench for float_to_int: directed vectors plus a cycle-level
// reference model of the conversion result and its latency.
module tb_float_to_int;

  logic clk;
  logic rst;
  float_to_int_if tbBus();

  float_to_int dut (.clk(clk), .rst(rst), .bus(tbBus));

  int errors = 0;
  int checks = 0;
  int cycleCount = 0;
  int acceptEdge = 0;

  logic        mBusy = 1'b0;
  logic        mDone = 1'b0;
  logic [31:0] mInt  = 32'd0;
  logic        mOv   = 1'b0;
  int          mRemain = 0;
  logic [31:0] pInt;
  logic        pOv;
  int          pLat;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference conversion from the numeric value, not from any shifter structure
  function automatic void refConvert(input logic [31:0] f, output logic [31:0] val,
                                     output logic ov, output int lat);
    int     e;
    longint sig;
    longint mag;
    longint sv;
    longint lim;
    e   = int'(f[30:23]);
    sig = longint'({40'd0, 1'b1, f[22:0]});
    lim = 64'sh0000_0000_8000_0000;
    if (e < 127)       mag = 0;
    else if (e >= 170) mag = 64'sh0000_0100_0000_0000;
    else if (e >= 150) mag = sig << (e - 150);
    else               mag = sig >> (150 - e);
    sv = f[31] ? -mag : mag;
    if (sv > lim - 1) begin
      val = 32'h7FFF_FFFF; ov = 1'b1;
    end else if (sv < -lim) begin
      val = 32'h8000_0000; ov = 1'b1;
    end else begin
      val = sv[31:0];      ov = 1'b0;
    end
    if (e >= 127 && e <= 157) lat = ((e >= 150) ? (e - 150) : (150 - e)) + 2;
    else                      lat = 2;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] expInt, input logic expOv);
    check32({name, ".intOut"}, tbBus.intOut, expInt);
    check32({name, ".OV"}, 32'(tbBus.OV), 32'(expOv));
  endtask

  task automatic applyStimulus(input logic [31:0] value);
    @(negedge clk);
    tbBus.start   = 1'b1;
    tbBus.floatIn = value;
    @(posedge clk);
    #1 acceptEdge = cycleCount;
    @(negedge clk);
    tbBus.start = 1'b0;
  endtask

  task automatic waitDone(output int rel);
    rel = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tbBus.done) begin
        rel = cycleCount - acceptEdge;
        break;
      end
    end
  endtask

  // Timing/result model advanced on each active edge
  always @(posedge clk) begin
    cycleCount++;
    mDone = 1'b0;
    if (rst) begin
      mBusy = 1'b0; mRemain = 0; mInt = 32'd0; mOv = 1'b0;
    end else if (!mBusy) begin
      if (tbBus.start) begin
        refConvert(tbBus.floatIn, pInt, pOv, pLat);
        mBusy   = 1'b1;
        mRemain = pLat;
      end
    end else begin
      mRemain--;
      if (mRemain == 0) begin
        mBusy = 1'b0; mDone = 1'b1; mInt = pInt; mOv = pOv;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (cycleCount > 0) begin
      check32("cycle.busy", 32'(tbBus.busy), 32'(mBusy));
      check32("cycle.done", 32'(tbBus.done), 32'(mDone));
      check32("cycle.intOut", tbBus.intOut, mInt);
      check32("cycle.OV", 32'(tbBus.OV), 32'(mOv));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  logic [31:0] vecIn  [10];
  logic [31:0] vecOut [10];
  logic        vecOv  [10];
  int          vecLat [10];

  initial begin
    int rel;
    int doneCount;
    int doneEdges [3];
    logic [31:0] mv;
    logic        mo;
    int          ml;

    vecIn[0] = 32'h3F80_0000; vecOut[0] = 32'h0000_0001; vecOv[0] = 1'b0; vecLat[0] = 25;
    vecIn[1] = 32'hC020_0000; vecOut[1] = 32'hFFFF_FFFE; vecOv[1] = 1'b0; vecLat[1] = 24;
    vecIn[2] = 32'h4E80_0000; vecOut[2] = 32'h4000_0000; vecOv[2] = 1'b0; vecLat[2] = 9;
    vecIn[3] = 32'hCF00_0000; vecOut[3] = 32'h8000_0000; vecOv[3] = 1'b0; vecLat[3] = 2;
    vecIn[4] = 32'h3F40_0000; vecOut[4] = 32'h0000_0000; vecOv[4] = 1'b0; vecLat[4] = 2;
    vecIn[5] = 32'h8000_0000; vecOut[5] = 32'h0000_0000; vecOv[5] = 1'b0; vecLat[5] = 2;
    vecIn[6] = 32'h0000_0001; vecOut[6] = 32'h0000_0000; vecOv[6] = 1'b0; vecLat[6] = 2;
    vecIn[7] = 32'h5015_02F9; vecOut[7] = 32'h7FFF_FFFF; vecOv[7] = 1'b1; vecLat[7] = 2;
    vecIn[8] = 32'hFF80_0000; vecOut[8] = 32'h8000_0000; vecOv[8] = 1'b1; vecLat[8] = 2;
    vecIn[9] = 32'h7FC0_0000; vecOut[9] = 32'h7FFF_FFFF; vecOv[9] = 1'b1; vecLat[9] = 2;

    // Pin the reference model to hand-computed values
    refConvert(32'h3F80_0000, mv, mo, ml);
    check32("model.one", mv, 32'h0000_0001);
    check32("model.oneLat", 32'(ml), 32'd25);
    refConvert(32'hC020_0000, mv, mo, ml);
    check32("model.minus2p5", mv, 32'hFFFF_FFFE);
    refConvert(32'hCF00_0000, mv, mo, ml);
    check32("model.minInt", mv, 32'h8000_0000);
    check32("model.minIntOv", 32'(mo), 32'd0);
    refConvert(32'h5015_02F9, mv, mo, ml);
    check32("model.sat", mv, 32'h7FFF_FFFF);
    check32("model.satOv", 32'(mo), 32'd1);

    rst = 1'b1;
    tbBus.start = 1'b0;
    tbBus.floatIn = 32'd0;
    repeat (2) @(negedge clk);
    checkOutput("reset", 32'h0000_0000, 1'b0);
    check32("reset.busy", 32'(tbBus.busy), 32'd0);
    check32("reset.done", 32'(tbBus.done), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecIn[i]);
      waitDone(rel);
      check32($sformatf("vec%0d.doneEdge", i), 32'(rel), 32'(vecLat[i]));
      checkOutput($sformatf("vec%0d", i), vecOut[i], vecOv[i]);
    end

    // Reset in the middle of a 1.0 conversion must abort it silently
    applyStimulus(32'h3F80_0000);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check32("abort.busy", 32'(tbBus.busy), 32'd0);
    checkOutput("abort", 32'h0000_0000, 1'b0);
    doneCount = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (tbBus.done) doneCount++;
    end
    check32("abort.noDone", 32'(doneCount), 32'd0);
    applyStimulus(32'h4000_0000);
    waitDone(rel);
    check32("afterAbort.doneEdge", 32'(rel), 32'd24);
    checkOutput("afterAbort", 32'h0000_0002, 1'b0);

    // A start pulse while busy is dropped
    applyStimulus(32'h3F80_0000);
    repeat (2) @(negedge clk);
    tbBus.start = 1'b1;
    tbBus.floatIn = 32'h4E80_0000;
    @(negedge clk);
    tbBus.start = 1'b0;
    doneCount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tbBus.done) doneCount++;
    end
    check32("ignored.doneCount", 32'(doneCount), 32'd1);
    checkOutput("ignored", 32'h0000_0001, 1'b0);

    // Start held high gives back-to-back conversions
    @(negedge clk);
    tbBus.start = 1'b1;
    tbBus.floatIn = 32'h3F80_0000;
    @(posedge clk);
    #1 acceptEdge = cycleCount;
    doneCount = 0;
    doneEdges[0] = -1; doneEdges[1] = -1; doneEdges[2] = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tbBus.done) begin
        doneEdges[doneCount] = cycleCount - acceptEdge;
        doneCount++;
        if (doneCount == 3) break;
      end
    end
    tbBus.start = 1'b0;
    check32("held.done0", 32'(doneEdges[0]), 32'd25);
    check32("held.done1", 32'(doneEdges[1]), 32'd51);
    check32("held.done2", 32'(doneEdges[2]), 32'd77);
    checkOutput("held", 32'h0000_0001, 1'b0);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/float_to_int.md
# float_to_int

Sequential IEEE-754 single-precision to 32-bit signed integer converter; the unpacking counterpart of the floating-point adder datapath. It captures a float on a start pulse and splits it into sign, exponent and mantissa registers. The significand is aligned by a bit-serial shift register under a shift counter, and the two's-complement integer result is returned with a one-cycle done pulse. It sits beside the adder so that adder results can be consumed by integer logic.

## Interface
- No parameters; widths are fixed by IEEE-754 single precision (1/8/23) and a 32-bit integer result.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request. Sampled only in IDLE.
- floatIn  input  32  operand: [31] sign, [30:23] exponent, [22:0] mantissa.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse; intOut and OV are valid from this cycle.
- OV  output  1  result was saturated (out of range, Inf or NaN).
- intOut  output  32  signed result, truncated toward zero; held until the next done.

## Operation
- States: IDLE, CLASSIFY, SHIFT, FINISH.
- **IDLE.** If start=1 at an edge, latch sign S, exponent E and mantissa M, then go to CLASSIFY. Otherwise stay in IDLE; floatIn is ignored.
- **CLASSIFY.** Act on E:
  - E<127 (zeros, denormals, |x|<1): result 0, OV=0, N=0, go to FINISH.
  - E=158 with S=1 and M=0: exactly -2^31, result 0x80000000, OV=0, go to FINISH.
  - E>=158 otherwise, including Inf/NaN: saturate to 0x7FFFFFFF if S=0 or 0x80000000 if S=1, OV=1, go to FINISH.
  - 127<=E<=157: load the 32-bit shift register with {8'b0, 1'b1, M}.
    - E<150: direction right, N=150-E (1..23).
    - E>150: direction left, N=E-150 (1..7).
    - E=150: N=0, go straight to FINISH.
    - Otherwise go to SHIFT.
- **SHIFT.** Shift once per edge in the latched direction; bits shifted out are discarded and zeros are filled in. Decrement the 5-bit counter. On the edge where the counter equals 1, go to FINISH.
- **FINISH.**
  - Result path: intOut <= S ? (~R + 1) : R, where R is the shift register value.
  - Special-case path: intOut <= the special value chosen in CLASSIFY.
  - Register OV, pulse done, return to IDLE.
- No overflow is possible on the shift path: the largest value is 0x7FFFFF80 at E=157.
- start while busy=1 is ignored and is not queued.
- rst at any edge, including mid-SHIFT: state=IDLE, intOut=0, OV=0, done=0, busy=0, counter=0. The aborted conversion produces no done.

## Timing
- Reset values: busy=0, done=0, OV=0, intOut=0x00000000.
- Take edge 0 as the edge where start is accepted:
  - busy is high from after edge 0 until edge N+2.
  - done is high for exactly one cycle, after edge N+2.
  - The next start can be accepted at edge N+3.
- Latency is N+2 edges from acceptance to done:
  - Minimum 2 (special cases, or E=150).
  - Maximum 25 (E=127, N=23).
- start held high continuously: back-to-back conversions, one every N+3 edges.
- intOut and OV change only at the FINISH edge or at reset.

## Test plan
- Reset mid-operation: start 0x3F800000, then assert rst at edge 5 -> no done; busy=0 and intOut=0x00000000 next cycle; a new start 0x40000000 afterwards -> intOut=0x00000002.
- Right shift: 0x3F800000 (1.0) -> intOut=0x00000001, OV=0, done after edge 25. 0xC0200000 (-2.5) -> intOut=0xFFFFFFFE (-2, truncation), done after edge 24.
- Left shift and boundary: 0x4E800000 (2^30) -> 0x40000000, done after edge 9. 0xCF000000 (-2^31) -> 0x80000000, OV=0, done after edge 2.
- Small and zero values: 0x3F400000 (0.75), 0x80000000 (-0.0) and 0x00000001 (denormal) -> each intOut=0x00000000, OV=0, done after edge 2.
- Saturation: 0x501502F9 (1e10) -> 0x7FFFFFFF, OV=1. 0xFF800000 (-Inf) -> 0x80000000, OV=1. 0x7FC00000 (NaN) -> 0x7FFFFFFF, OV=1.
- Handshake: pulse start again at edge 3 during a 1.0 conversion -> ignored, exactly one done. Start held high -> dones after edges 25, 51, 77.
